// File: rtl/mips_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_loader_pkg
// Description : Shared types and constants for the instruction-memory loader:
//               loader FSM state encoding, length-field width and bytes per
//               imem word.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_loader_pkg;

  // Loader FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam int LEN_W          = 16;  // width of the frame word-count field
  localparam int BYTES_PER_WORD = 4;   // stream bytes per imem word

endpackage : mips_loader_pkg
`default_nettype wire

// File: rtl/loader_word_asm.sv
`default_nettype none
// ============================================================================
// Module      : loader_word_asm
// Description : Assembles a big-endian 32-bit word from four accepted stream
//               bytes (first byte lands in bits 31:24). Emits a one-cycle
//               word_valid pulse the cycle after the fourth byte; word holds
//               the last completed word until the next one completes.
// Ports       : clock, reset (async, active-high)
//               clear      - synchronous restart of the byte position
//               byte_valid - a data byte is accepted this cycle
//               byte_in    - the accepted byte
//               byte_idx   - position (0..3) the next accepted byte fills
//               word_valid - completed-word strobe
//               word       - completed word
// Revision    : 1.0 - initial release
// ============================================================================
module loader_word_asm
  import mips_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  // Only the first three bytes need storing; the fourth goes straight into word.
  logic [23:0] shift;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      byte_idx   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clear) begin
      shift      <= '0;
      byte_idx   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        shift    <= {shift[15:0], byte_in};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == LAST_IDX) begin
          word       <= {shift, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule : loader_word_asm
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a program image as a byte stream (valid/ready),
//               frame = LEN_HI, LEN_LO, 4*N data bytes, XOR check byte.
//               Writes big-endian words to imem addresses 0..N-1 and holds
//               the CPU until the image is complete and its checksum matches.
// Ports       : clock, reset (async, active-high), start (load pulse)
//               in_valid/in_data/in_ready - byte stream handshake
//               imem_we/imem_addr/imem_wdata - imem write port
//               cpu_hold - CPU held while not DONE
//               done     - image loaded and verified
//               error    - bad checksum or word count above DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W:0] DEPTH_CMP = (LEN_W + 1)'(DEPTH);
  localparam logic [1:0]     LAST_IDX  = 2'(BYTES_PER_WORD - 1);

  state_t           state;
  state_t           state_nx;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_cnt;   // index of the word currently being assembled
  logic [7:0]       checksum;

  logic             accept;
  logic             restart;
  logic [LEN_W-1:0] len_rx;
  logic             len_too_big;
  logic             last_word;
  logic             word_end;
  logic [1:0]       byte_idx;

  assign accept      = in_valid & in_ready;
  assign len_rx      = {len_hi, in_data};
  // Compare one bit wider so the check stays unsigned for any DEPTH.
  assign len_too_big = {1'b0, len_rx} > DEPTH_CMP;
  assign last_word   = (word_cnt + LEN_W'(1)) == len;
  assign word_end    = accept && (state == DATA) && (byte_idx == LAST_IDX);
  assign restart     = start && (state == IDLE || state == DONE || state == ERROR);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_nx = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_nx = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if (len_too_big)      state_nx = ERROR;
          else if (len_rx == 0) state_nx = CHECK;
          else                  state_nx = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (word_end && last_word) state_nx = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (accept) state_nx = (in_data == checksum) ? DONE : ERROR;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign done     = (state == DONE);
  assign error    = (state == ERROR);
  assign cpu_hold = (state != DONE);

  // --------------------------------------------------------------------------
  // Length, checksum and write-address tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_hi    <= '0;
      len       <= '0;
      word_cnt  <= '0;
      checksum  <= '0;
      imem_addr <= '0;
    end else if (restart) begin
      len_hi    <= '0;
      len       <= '0;
      word_cnt  <= '0;
      checksum  <= '0;
      imem_addr <= '0;
    end else begin
      // The check byte itself is excluded from the running XOR.
      if (accept && state != CHECK) checksum <= checksum ^ in_data;
      if (accept && state == LEN_HI) len_hi <= in_data;
      if (accept && state == LEN_LO) len <= len_rx;
      // Address is latched with the final byte so it lines up with the
      // assembler's write strobe one cycle later.
      if (word_end) begin
        imem_addr <= word_cnt[ADDR_W-1:0];
        word_cnt  <= word_cnt + LEN_W'(1);
      end
    end
  end

  loader_word_asm u_word_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (accept && state == DATA),
    .byte_in    (in_data),
    .byte_idx   (byte_idx),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader. The driver sends frames and
//               pushes expected writes / outcomes (with their expected sample
//               time) into queues; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; time t; } wr_t;
  typedef struct { bit is_err; time t; } oc_t;

  wr_t exp_wr[$];
  oc_t exp_oc[$];
  int  passed = 0;
  int  total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  bit prev_done = 0, prev_err = 0;
  always @(negedge clock) begin
    if (imem_we) begin
      if (exp_wr.size() == 0) chk("unexpected_write", {56'd0, imem_addr}, 64'hFFFF);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(e.addr));
        chk("wr_data", 64'(imem_wdata), 64'(e.data));
        chk("wr_time", 64'($time), 64'(e.t));
      end
    end
    if ((done && !prev_done) || (error && !prev_err)) begin
      if (exp_oc.size() == 0) chk("unexpected_outcome", {62'd0, done, error}, 64'd0);
      else begin
        oc_t o;
        o = exp_oc.pop_front();
        chk("outcome_err", 64'(error), 64'(o.is_err));
        chk("outcome_done", 64'(done), 64'(!o.is_err));
        chk("outcome_time", 64'($time), 64'(o.t));
      end
    end
    prev_done = done;
    prev_err  = error;
  end

  // ---------------- reference model: frame construction ----------------
  task automatic make_frame(input logic [31:0] wq[$], input logic [15:0] n, input bit bad,
                            output logic [7:0] fb[$]);
    logic [7:0] x;
    fb = {};
    fb.push_back(n[15:8]);
    fb.push_back(n[7:0]);
    foreach (wq[k]) begin
      fb.push_back(wq[k][31:24]); fb.push_back(wq[k][23:16]);
      fb.push_back(wq[k][15:8]);  fb.push_back(wq[k][7:0]);
    end
    x = 8'h00;
    foreach (fb[k]) x ^= fb[k];
    fb.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends bytes of a frame and derives expectations from the frame rules:
  // word k written 1 cycle after its last byte, outcome 1 cycle after the
  // deciding byte (LEN_LO for oversize, the check byte otherwise).
  task automatic send_frame(input logic [7:0] fb[$], input int max_gap,
                            input bit poke_start, input int stop_after);
    int unsigned n_words;
    logic [7:0]  x;
    logic [31:0] w;
    time         t;
    bit          ok, rdy;
    x = 0; w = 0; n_words = 0; t = 0;
    for (int i = 0; i < fb.size() && i < stop_after; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        start = poke_start && ($urandom_range(0, 1) == 1);
        @(posedge clock); #1;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = fb[i];
      ok = 0;
      for (int c = 0; c < 64; c++) begin
        @(negedge clock); rdy = in_ready;
        @(posedge clock); t = $time; #1;
        if (rdy) begin ok = 1; break; end
      end
      in_valid = 1'b0;
      if (!ok) begin
        chk("accept_timeout", 64'd0, 64'd1);
        return;
      end
      if (i == 1) begin
        n_words = {fb[0], fb[1]};
        if (n_words > DEPTH) begin
          exp_oc.push_back('{is_err: 1'b1, t: t + 5});
          return;
        end
      end
      if (i >= 2 && i < 2 + 4 * n_words) begin
        w = {w[23:0], fb[i]};
        if ((i - 2) % 4 == 3)
          exp_wr.push_back('{addr: ADDR_W'((i - 2) / 4), data: w, t: t + 5});
      end
      if (i >= 2 && i == 2 + 4 * n_words)
        exp_oc.push_back('{is_err: (fb[i] != x), t: t + 5});
      x ^= fb[i];
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] wq[$];
    logic [7:0]  fb[$];
    logic [7:0]  fb_ok[$];

    idle(2);
    @(negedge clock);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    // Case 1: two-word image, back-to-back bytes
    wq = '{32'h20080005, 32'h00000000};
    make_frame(wq, 16'd2, 1'b0, fb_ok);
    chk("frame_check_byte", 64'(fb_ok[10]), 64'h2F);
    pulse_start();
    send_frame(fb_ok, 0, 1'b0, 1000);
    idle(3);
    chk("c1_done", 64'(done), 64'd1);
    chk("c1_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("c1_in_ready", 64'(in_ready), 64'd0);

    // Case 2: empty image
    wq = {};
    make_frame(wq, 16'd0, 1'b0, fb);
    pulse_start();
    chk("c2_hold_after_start", 64'(cpu_hold), 64'd1);
    send_frame(fb, 0, 1'b0, 1000);
    idle(3);
    chk("c2_done", 64'(done), 64'd1);

    // Case 3: bad check byte, then recovery
    wq = '{32'h20080005, 32'h00000000};
    make_frame(wq, 16'd2, 1'b1, fb);
    pulse_start();
    send_frame(fb, 0, 1'b0, 1000);
    idle(3);
    chk("c3_error", 64'(error), 64'd1);
    chk("c3_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("c3_done", 64'(done), 64'd0);
    pulse_start();
    send_frame(fb_ok, 0, 1'b0, 1000);
    idle(3);
    chk("c3_recover_done", 64'(done), 64'd1);
    chk("c3_recover_error", 64'(error), 64'd0);

    // Case 4: oversize word count
    wq = {};
    make_frame(wq, 16'h0101, 1'b0, fb);
    pulse_start();
    send_frame(fb, 0, 1'b0, 1000);
    idle(3);
    chk("c4_error", 64'(error), 64'd1);
    chk("c4_in_ready", 64'(in_ready), 64'd0);

    // Case 5: random gaps with ignored mid-frame start pulses
    pulse_start();
    send_frame(fb_ok, 5, 1'b1, 1000);
    idle(3);
    chk("c5_done", 64'(done), 64'd1);

    // Case 6: reset after 6 data bytes, then a clean reload
    pulse_start();
    send_frame(fb_ok, 0, 1'b0, 8);
    reset = 1'b1;
    @(negedge clock);
    chk("c6_in_ready", 64'(in_ready), 64'd0);
    chk("c6_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("c6_done", 64'(done), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);
    pulse_start();
    send_frame(fb_ok, 0, 1'b0, 1000);
    idle(3);
    chk("c6_done_reload", 64'(done), 64'd1);

    // Random frames
    for (int r = 0; r < 8; r++) begin
      int unsigned n;
      bit bad;
      n   = $urandom_range(0, 5);
      bad = ($urandom_range(0, 3) == 0);
      wq  = {};
      for (int k = 0; k < int'(n); k++) wq.push_back($urandom);
      make_frame(wq, 16'(n), bad, fb);
      pulse_start();
      send_frame(fb, 2, 1'b1, 1000);
      idle(3);
      chk("rnd_error", 64'(error), 64'(bad));
      chk("rnd_cpu_hold", 64'(cpu_hold), 64'(bad));
    end

    idle(5);
    chk("pending_writes", 64'(exp_wr.size()), 64'd0);
    chk("pending_outcomes", 64'(exp_oc.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_imem_loader
`default_nettype wire
